// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_pkg
//  Description : Alarm state encodings and time-field widths shared by the
//                alarm sequencer, time-keeping and display units.
//  Revision    : 1.0  initial release
// ============================================================================
package alarm_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } alm_state_e;

endpackage
`default_nettype wire

// File: rtl/tick_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tick_down_timer
//  Description : Loadable seconds down-counter. Decrements on each tick,
//                holds at zero, and flags the tick that expires it.
//  Revision    : 1.0  initial release
// ============================================================================
module tick_down_timer #(
    parameter int TW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [TW-1:0] load_val_i,
    input  logic          load_i,
    input  logic          tick_i,
    output logic          done_o
);

    logic [TW-1:0] cnt_q;

    // Expiry is the tick that takes the counter from 1 to 0.
    assign done_o = tick_i && (cnt_q == TW'(1));

    // Load has priority over counting; zero is held rather than wrapped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - TW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alarm_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_ctrl_unit
//  Description : Alarm sequencer in front of the piezo driver. Matches the
//                running clock against the alarm time, rings, handles the
//                stop/snooze keys and auto-stops after a ring timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module alarm_ctrl_unit
    import alarm_pkg::*;
#(
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int SNOOZE_SEC       = 300,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SEC_TICK,
    input  logic [HOUR_W-1:0] CUR_HOUR,
    input  logic [MIN_W-1:0]  CUR_MIN,
    input  logic [SEC_W-1:0]  CUR_SEC,
    input  logic [HOUR_W-1:0] ALM_HOUR,
    input  logic [MIN_W-1:0]  ALM_MIN,
    input  logic              ALARM_ON,
    input  logic              KEY_STOP,
    input  logic              KEY_SNOOZE,
    output logic              ALARM_ENABLE,
    output logic              ALARM_DOING,
    output logic              SNOOZE_ACTIVE,
    output logic [1:0]        ALM_STATE
);

    localparam int TMAX = (RING_TIMEOUT_SEC > SNOOZE_SEC) ? RING_TIMEOUT_SEC : SNOOZE_SEC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

    localparam logic [TW-1:0] C_RING_LOAD   = TW'(RING_TIMEOUT_SEC);
    localparam logic [TW-1:0] C_SNOOZE_LOAD = TW'(SNOOZE_SEC);
    localparam logic [CW-1:0] C_MAX_SNOOZE  = CW'(MAX_SNOOZE);

    alm_state_e    state_q, state_d;
    logic [CW-1:0] snz_cnt_q, snz_cnt_d;
    logic          enable_q, doing_q, snooze_q;
    logic [1:0]    alm_state_q;

    logic          tmr_load, tmr_tick, tmr_done;
    logic [TW-1:0] tmr_val;
    logic          time_match;

    // Ring timeout and snooze never overlap, so one timer serves both.
    tick_down_timer #(
        .TW (TW)
    ) u_timer (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .load_val_i (tmr_val),
        .load_i     (tmr_load),
        .tick_i     (tmr_tick),
        .done_o     (tmr_done)
    );

    assign time_match = (CUR_HOUR == ALM_HOUR) && (CUR_MIN == ALM_MIN) && (CUR_SEC == '0);

    // Next-state, snooze count and timer control; keys pre-empt the tick.
    always_comb begin
        state_d   = state_q;
        snz_cnt_d = snz_cnt_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_tick  = 1'b0;
        if (!ALARM_ON) begin
            state_d   = ST_IDLE;
            snz_cnt_d = '0;
            tmr_load  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (SEC_TICK && time_match) begin
                        state_d   = ST_RINGING;
                        snz_cnt_d = '0;
                        tmr_load  = 1'b1;
                        tmr_val   = C_RING_LOAD;
                    end
                end
                ST_RINGING: begin
                    if (KEY_STOP) begin
                        state_d   = ST_ARMED;
                        snz_cnt_d = '0;
                    end else if (KEY_SNOOZE && (snz_cnt_q < C_MAX_SNOOZE)) begin
                        state_d   = ST_SNOOZE;
                        snz_cnt_d = snz_cnt_q + CW'(1);
                        tmr_load  = 1'b1;
                        tmr_val   = C_SNOOZE_LOAD;
                    end else if (SEC_TICK) begin
                        tmr_tick = 1'b1;
                        if (tmr_done) begin
                            state_d   = ST_ARMED;
                            snz_cnt_d = '0;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (KEY_STOP) begin
                        state_d   = ST_ARMED;
                        snz_cnt_d = '0;
                    end else if (SEC_TICK) begin
                        tmr_tick = 1'b1;
                        if (tmr_done) begin
                            state_d  = ST_RINGING;
                            tmr_load = 1'b1;
                            tmr_val  = C_RING_LOAD;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, snooze count and outputs decoded from the next state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            snz_cnt_q   <= '0;
            enable_q    <= 1'b0;
            doing_q     <= 1'b0;
            snooze_q    <= 1'b0;
            alm_state_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            snz_cnt_q   <= snz_cnt_d;
            enable_q    <= (state_d != ST_IDLE);
            doing_q     <= (state_d == ST_RINGING);
            snooze_q    <= (state_d == ST_SNOOZE);
            alm_state_q <= state_d;
        end
    end

    assign ALARM_ENABLE  = enable_q;
    assign ALARM_DOING   = doing_q;
    assign SNOOZE_ACTIVE = snooze_q;
    assign ALM_STATE     = alm_state_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_ctrl_unit
//  Description : Table-driven bench for alarm_ctrl_unit with a few
//                hand-written multi-cycle sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alarm_ctrl_unit;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       SEC_TICK;
    logic [4:0] CUR_HOUR;
    logic [5:0] CUR_MIN;
    logic [5:0] CUR_SEC;
    logic [4:0] ALM_HOUR;
    logic [5:0] ALM_MIN;
    logic       ALARM_ON;
    logic       KEY_STOP;
    logic       KEY_SNOOZE;
    logic       ALARM_ENABLE;
    logic       ALARM_DOING;
    logic       SNOOZE_ACTIVE;
    logic [1:0] ALM_STATE;

    int checks = 0;
    int errors = 0;

    alarm_ctrl_unit #(
        .RING_TIMEOUT_SEC (5),
        .SNOOZE_SEC       (3),
        .MAX_SNOOZE       (2)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .SEC_TICK      (SEC_TICK),
        .CUR_HOUR      (CUR_HOUR),
        .CUR_MIN       (CUR_MIN),
        .CUR_SEC       (CUR_SEC),
        .ALM_HOUR      (ALM_HOUR),
        .ALM_MIN       (ALM_MIN),
        .ALARM_ON      (ALARM_ON),
        .KEY_STOP      (KEY_STOP),
        .KEY_SNOOZE    (KEY_SNOOZE),
        .ALARM_ENABLE  (ALARM_ENABLE),
        .ALARM_DOING   (ALARM_DOING),
        .SNOOZE_ACTIVE (SNOOZE_ACTIVE),
        .ALM_STATE     (ALM_STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       on;
        logic       stop;
        logic       snz;
        logic       tick;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] exp_st;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic on, input logic stop, input logic snz,
                                input logic tick, input int h, input int m, input int s,
                                input int st);
        vec_t v;
        v.on = on; v.stop = stop; v.snz = snz; v.tick = tick;
        v.h = 5'(h); v.m = 6'(m); v.s = 6'(s); v.exp_st = 2'(st);
        return v;
    endfunction

    // Expected {ALM_STATE, ENABLE, DOING, SNOOZE_ACTIVE} for a given state.
    function automatic logic [4:0] expv(input logic [1:0] st);
        logic [4:0] e;
        case (st)
            2'd0:    e = 5'b00_000;
            2'd1:    e = 5'b01_100;
            2'd2:    e = 5'b10_110;
            default: e = 5'b11_101;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [1:0] st);
        logic [4:0] act;
        act = {ALM_STATE, ALARM_ENABLE, ALARM_DOING, SNOOZE_ACTIVE};
        checks++;
        if (act !== expv(st)) begin
            errors++;
            $display("FAIL %s: got {state,en,doing,snz}=%b, expected %b", name, act, expv(st));
        end
    endtask

    task automatic idle_inputs();
        SEC_TICK = 1'b0; KEY_STOP = 1'b0; KEY_SNOOZE = 1'b0;
    endtask

    // One clock with the current inputs, then sample on the falling edge.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
        idle_inputs();
    endtask

    // Nine quiet cycles followed by a one-cycle SEC_TICK at the given time.
    task automatic tick_at(input int h, input int m, input int s);
        repeat (9) step();
        CUR_HOUR = 5'(h); CUR_MIN = 6'(m); CUR_SEC = 6'(s);
        SEC_TICK = 1'b1;
        step();
    endtask

    initial begin
        RESET = 1'b1; ALARM_ON = 1'b0;
        CUR_HOUR = 5'd0; CUR_MIN = 6'd0; CUR_SEC = 6'd0;
        ALM_HOUR = 5'd7; ALM_MIN = 6'd30;
        idle_inputs();
        @(negedge CLK);
        step();
        step();
        check("reset_state", 2'd0);
        RESET = 1'b0;

        //                on stp snz tck  h   m   s  exp
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));   // enable -> ARMED
        tbl.push_back(mk(1, 0, 0, 1, 7, 29, 59, 1)); // not yet
        tbl.push_back(mk(1, 0, 0, 1, 7, 30, 0, 2));  // match -> RINGING
        tbl.push_back(mk(1, 0, 0, 1, 7, 30, 1, 2));
        tbl.push_back(mk(1, 0, 0, 1, 7, 30, 2, 2));
        tbl.push_back(mk(1, 0, 0, 1, 7, 30, 3, 2));
        tbl.push_back(mk(1, 0, 0, 1, 7, 30, 4, 2));
        tbl.push_back(mk(1, 0, 0, 1, 7, 30, 5, 1));  // 5th tick auto-stop
        tbl.push_back(mk(1, 0, 0, 1, 7, 30, 6, 1));  // same minute, no re-ring
        tbl.push_back(mk(1, 0, 0, 1, 8, 30, 0, 1));  // wrong hour
        tbl.push_back(mk(1, 0, 0, 1, 7, 31, 0, 1));  // wrong minute
        tbl.push_back(mk(1, 0, 0, 1, 7, 30, 0, 2));  // ring
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1));   // stop
        tbl.push_back(mk(1, 0, 0, 1, 7, 30, 1, 1));  // no re-ring
        tbl.push_back(mk(1, 0, 0, 1, 7, 30, 0, 2));  // ring
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 3));   // snooze #1
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 3));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 3));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 3));   // snooze key ignored in SNOOZE
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 2));   // 3rd tick -> re-ring
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 3));   // snooze #2
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 3));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 3));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 2));   // snooze #3 refused
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1));   // timeout, count cleared
        tbl.push_back(mk(1, 0, 0, 1, 7, 30, 0, 2));  // ring again
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 3));   // snooze allowed again
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1));   // stop from SNOOZE
        tbl.push_back(mk(1, 0, 0, 1, 7, 30, 0, 2));  // ring
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1));   // stop+snooze: stop wins
        tbl.push_back(mk(1, 0, 0, 1, 7, 30, 0, 2));  // ring, timer 5
        tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, 3));   // snooze+tick: tick dropped
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 3));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 3));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 2));   // exactly 3 ticks
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1));   // stop+tick
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1));   // keys ignored in ARMED
        tbl.push_back(mk(1, 0, 0, 1, 7, 30, 0, 2));  // ring
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 3));   // snooze
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));   // switch off -> IDLE
        tbl.push_back(mk(0, 0, 0, 1, 7, 30, 0, 0));  // stays off
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));   // re-enable -> ARMED

        for (int i = 0; i < tbl.size(); i++) begin
            ALARM_ON   = tbl[i].on;
            KEY_STOP   = tbl[i].stop;
            KEY_SNOOZE = tbl[i].snz;
            SEC_TICK   = tbl[i].tick;
            CUR_HOUR   = tbl[i].h;
            CUR_MIN    = tbl[i].m;
            CUR_SEC    = tbl[i].s;
            step();
            check($sformatf("vec%0d", i), tbl[i].exp_st);
        end

        // Ring with ticks every 10 clocks; alarm time edited mid-ring.
        tick_at(7, 30, 0);
        check("seq_ring_start", 2'd2);
        ALM_MIN = 6'd45;
        tick_at(7, 30, 1);
        tick_at(7, 30, 2);
        tick_at(7, 30, 3);
        tick_at(7, 30, 4);
        check("seq_alm_edit_still_ringing", 2'd2);
        tick_at(7, 30, 5);
        check("seq_timeout_spaced", 2'd1);
        tick_at(7, 30, 0);
        check("seq_old_time_no_ring", 2'd1);
        ALM_MIN = 6'd30;

        // Reset during RINGING with the alarm switch left on.
        tick_at(7, 30, 0);
        check("seq_ring_before_reset", 2'd2);
        RESET = 1'b1;
        step();
        check("seq_reset_mid_ring", 2'd0);
        RESET = 1'b0;
        step();
        check("seq_after_reset_armed", 2'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
